irrigation_zone_ctrl: RTL and testbench
=======================================

// Module: irrigation_zone_ctrl
// PURPOSE
//  Multi-zone irrigation controller. Generalises the single-line sprinkler/drip controller to ZONES zones
//  sharing one water tank. Adds a parametrised tank level, a built-in tick prescaler, round-robin zone
//  arbitration, per-zone error flags and a timed post-fertiliser cleaning cycle.
//  Sits between the field request inputs and the valve/zone drivers.
// PARAMETERS
//  ZONES       4   number of irrigation zones (>=2)
//  LEVEL_W     3   width of tank level counter
//  LEVEL_MAX   7   full-tank level; fill stops here (<= 2^LEVEL_W-1)
//  LOW_LVL     2   fill threshold; level <= LOW_LVL forces FILL
//  PRESCALE    32  clock cycles per tick (>=2); replaces external divider chain
//  DRIP_DIV    2   drip mode drains 1 level every DRIP_DIV ticks (>=1)
//  CLEAN_TICKS 4   length of cleaning cycle in ticks (>=1)
// PORTS
//  clock      in   1        system clock, all state on rising edge
//  reset      in   1        asynchronous, active-low reset
//  asp        in   ZONES    per-zone sprinkler request
//  got        in   ZONES    per-zone drip request
//  adb        in   ZONES    per-zone fertiliser request (sampled at grant)
//  zone_on    out  ZONES    one-hot active zone valve (all 0 when not irrigating)
//  mode       out  1        1 = sprinkler, 0 = drip (valid while zone_on != 0, else 0)
//  VE         out  1        tank fill valve open
//  cout_Nivel out  LEVEL_W  current tank level
//  limpeza    out  2        00 none, 01 clean pending, 10 cleaning
//  erro       out  ZONES    zone has asp & got both set (registered every clock)
//  tick       out  1        one-clock pulse every PRESCALE clocks
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE, cout_Nivel=0, VE=0, zone_on=0, mode=0, limpeza=00, erro=0,
//    tick=0, prescaler=0, fert flag=0, RR pointer=ZONES-1 (zone 0 has first priority).
//  - Prescaler counts 0..PRESCALE-1; tick=1 for the clock where count==PRESCALE-1. First tick occurs
//    PRESCALE clocks after reset release.
//  - State, level and all outputs except erro/tick change only on edges where tick=1; erro updates every clock.
//  - Valid request for zone i: asp[i]^got[i]. Both set -> invalid and erro[i]=1.
//  - FSM states: IDLE, FILL, IRRIGATE, CLEAN.
//  - IDLE: level<=LOW_LVL -> FILL (VE=1). Otherwise, any valid request -> IRRIGATE.
//    Grant the first valid zone after the RR pointer, wrapping. Pointer := grant.
//    mode := asp[g]; fert flag := adb[g]&asp[g]; drip counter cleared.
//  - IRRIGATE, per tick:
//    - if the zone g request is no longer valid -> exit without drain:
//      CLEAN if fert flag set, else IDLE.
//    - else drain level: 1 per tick for sprinkler, 1 per DRIP_DIV ticks for drip.
//      If the resulting level<=LOW_LVL -> FILL (zone released; fert flag kept).
//  - FILL: VE=1; level+1 per tick, saturating at LEVEL_MAX.
//    On reaching LEVEL_MAX: VE=0, then CLEAN if fert flag set, else IDLE.
//  - CLEAN: zone_on=0, VE=0, level held, requests ignored, limpeza=10 for exactly CLEAN_TICKS ticks.
//    Then fert flag:=0 -> IDLE.
//  - limpeza=01 whenever fert flag=1 and state!=CLEAN.
//  - Level never underflows below 0 or exceeds LEVEL_MAX. FILL has priority over new grants.
//  - Simultaneous request drop and low level in the same tick: the request drop wins (no drain).
//  - Reset mid-operation: immediate return to reset values; a pending clean is discarded.
// TESTING  (PRESCALE=4, LEVEL_MAX=7, LOW_LVL=2, ZONES=4, DRIP_DIV=2, CLEAN_TICKS=4)
//  1 Release reset, no requests -> first tick: VE=1; level 0->7 over 7 ticks; then VE=0, IDLE.
//  2 Full tank, asp=0010 -> zone_on=0010, mode=1; level 7->2 over 5 ticks; then zone_on=0, VE=1.
//  3 Full tank, got=0001 -> zone_on=0001, mode=0; level decrements every 2nd tick (7,7,6,6,5...).
//  4 asp=0100, got=0100 -> erro=0100 one clock later; zone_on stays 0.
//  5 asp=1001 held -> zone 0 granted; after the low-level FILL completes, zone 3 is granted (round-robin).
//  6 asp=0010, adb=0010, then drop asp -> limpeza=01 during irrigation, then 10 for 4 ticks, then 00.
//    Assert reset mid-clean -> all outputs 0 at once.

Source files
------------

// File: rtl/irrigation_zone_ctrl.sv
// Multi-zone irrigation controller: one shared tank, round-robin zone grants,
// tick-paced fill/drain and a timed cleaning cycle after fertiliser use.
module irrigation_zone_ctrl #(
  parameter int ZONES       = 4,
  parameter int LEVEL_W     = 3,
  parameter int LEVEL_MAX   = 7,
  parameter int LOW_LVL     = 2,
  parameter int PRESCALE    = 32,
  parameter int DRIP_DIV    = 2,
  parameter int CLEAN_TICKS = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [ZONES-1:0]   asp,
  input  logic [ZONES-1:0]   got,
  input  logic [ZONES-1:0]   adb,
  output logic [ZONES-1:0]   zone_on,
  output logic               mode,
  output logic               VE,
  output logic [LEVEL_W-1:0] cout_Nivel,
  output logic [1:0]         limpeza,
  output logic [ZONES-1:0]   erro,
  output logic               tick
);

  localparam int PS_W  = $clog2(PRESCALE);
  localparam int PTR_W = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int DR_W  = $clog2(DRIP_DIV) + 1;
  localparam int CL_W  = $clog2(CLEAN_TICKS) + 1;
  localparam logic [LEVEL_W-1:0] LMAX = LEVEL_W'(LEVEL_MAX);
  localparam logic [LEVEL_W-1:0] LLOW = LEVEL_W'(LOW_LVL);

  typedef enum logic [1:0] {IDLE, FILL, IRRIGATE, CLEAN} state_t;

  state_t             state, state_nxt;
  logic [PS_W-1:0]    pre;
  logic [LEVEL_W-1:0] level, level_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt, grant;
  logic               mode_r, mode_nxt;
  logic               fert, fert_nxt;
  logic [DR_W-1:0]    drip_cnt, drip_nxt;
  logic [CL_W-1:0]    clean_cnt, clean_nxt;
  logic [ZONES-1:0]   valid;
  logic               found;

  function automatic logic [LEVEL_W-1:0] lvl_inc(input logic [LEVEL_W-1:0] l);
    return (l >= LMAX) ? LMAX : l + 1'b1;
  endfunction

  function automatic logic [LEVEL_W-1:0] lvl_dec(input logic [LEVEL_W-1:0] l);
    return (l == '0) ? '0 : l - 1'b1;
  endfunction

  assign tick  = (pre == PS_W'(PRESCALE - 1));
  assign valid = asp ^ got;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre  <= '0;
      erro <= '0;
    end else begin
      pre  <= tick ? '0 : pre + 1'b1;
      erro <= asp & got;
    end
  end

  // Round-robin search starts just after the last granted zone
  always_comb begin
    found = 1'b0;
    grant = ptr;
    for (int k = 1; k <= ZONES; k++) begin
      if (!found && valid[(int'(ptr) + k) % ZONES]) begin
        found = 1'b1;
        grant = PTR_W'((int'(ptr) + k) % ZONES);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      level     <= '0;
      ptr       <= PTR_W'(ZONES - 1);
      mode_r    <= 1'b0;
      fert      <= 1'b0;
      drip_cnt  <= '0;
      clean_cnt <= '0;
    end else if (tick) begin
      state     <= state_nxt;
      level     <= level_nxt;
      ptr       <= ptr_nxt;
      mode_r    <= mode_nxt;
      fert      <= fert_nxt;
      drip_cnt  <= drip_nxt;
      clean_cnt <= clean_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    ptr_nxt   = ptr;
    mode_nxt  = mode_r;
    fert_nxt  = fert;
    drip_nxt  = drip_cnt;
    clean_nxt = '0;
    case (state)
      IDLE: begin
        if (level <= LLOW) begin
          state_nxt = FILL;
        end else if (found) begin
          state_nxt = IRRIGATE;
          ptr_nxt   = grant;
          mode_nxt  = asp[grant];
          fert_nxt  = adb[grant] & asp[grant];
          drip_nxt  = '0;
        end
      end
      IRRIGATE: begin
        // A dropped request wins over draining, even if the tank is low
        if (!valid[ptr]) begin
          state_nxt = fert ? CLEAN : IDLE;
        end else begin
          if (mode_r) begin
            level_nxt = lvl_dec(level);
          end else if (drip_cnt == DR_W'(DRIP_DIV - 1)) begin
            level_nxt = lvl_dec(level);
            drip_nxt  = '0;
          end else begin
            drip_nxt = drip_cnt + 1'b1;
          end
          if (level_nxt <= LLOW) state_nxt = FILL;
        end
      end
      FILL: begin
        level_nxt = lvl_inc(level);
        if (level_nxt == LMAX) state_nxt = fert ? CLEAN : IDLE;
      end
      CLEAN: begin
        if (clean_cnt == CL_W'(CLEAN_TICKS - 1)) begin
          state_nxt = IDLE;
          fert_nxt  = 1'b0;
        end else begin
          clean_nxt = clean_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    zone_on    = '0;
    mode       = 1'b0;
    VE         = (state == FILL);
    cout_Nivel = level;
    limpeza    = 2'b00;
    if (state == IRRIGATE) begin
      zone_on = ZONES'(1) << ptr;
      mode    = mode_r;
    end
    if (state == CLEAN) limpeza = 2'b10;
    else if (fert)      limpeza = 2'b01;
  end

endmodule

// File: tb/tb_irrigation_zone_ctrl.sv
// Randomised and directed bench for irrigation_zone_ctrl against a tick-level
// behavioural model of the tank, zone arbitration and cleaning cycle.
module tb_irrigation_zone_ctrl;
  localparam int ZONES = 4, LEVEL_W = 3, LEVEL_MAX = 7, LOW_LVL = 2;
  localparam int PRESCALE = 4, DRIP_DIV = 2, CLEAN_TICKS = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [ZONES-1:0]   asp = '0, got = '0, adb = '0;
  logic [ZONES-1:0]   zone_on, erro;
  logic               mode, VE, tick;
  logic [LEVEL_W-1:0] cout_Nivel;
  logic [1:0]         limpeza;

  int errors = 0;
  int checks = 0;

  irrigation_zone_ctrl #(
    .ZONES(ZONES), .LEVEL_W(LEVEL_W), .LEVEL_MAX(LEVEL_MAX), .LOW_LVL(LOW_LVL),
    .PRESCALE(PRESCALE), .DRIP_DIV(DRIP_DIV), .CLEAN_TICKS(CLEAN_TICKS)
  ) dut (
    .clock(clock), .reset(reset), .asp(asp), .got(got), .adb(adb),
    .zone_on(zone_on), .mode(mode), .VE(VE), .cout_Nivel(cout_Nivel),
    .limpeza(limpeza), .erro(erro), .tick(tick)
  );

  always #5 clock = ~clock;

  // Model: zone index (-1 = none), fill flag, remaining cleaning ticks, clock edges since reset
  int m_lvl, m_zone, m_last, m_irr, m_clean, m_edges;
  bit m_fill, m_spr, m_fert;
  logic [ZONES-1:0] m_erro;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d required %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0; m_zone = -1; m_last = ZONES - 1; m_irr = 0; m_clean = 0; m_edges = 0;
    m_fill = 0; m_spr = 0; m_fert = 0; m_erro = '0;
  endtask

  task automatic model_tick();
    if (m_clean > 0) begin
      m_clean--;
      if (m_clean == 0) m_fert = 0;
    end else if (m_fill) begin
      m_lvl = (m_lvl + 1 > LEVEL_MAX) ? LEVEL_MAX : m_lvl + 1;
      if (m_lvl == LEVEL_MAX) begin
        m_fill = 0;
        if (m_fert) m_clean = CLEAN_TICKS;
      end
    end else if (m_zone >= 0) begin
      if (!(asp[m_zone] ^ got[m_zone])) begin
        m_zone = -1;
        if (m_fert) m_clean = CLEAN_TICKS;
      end else begin
        m_irr++;
        if (m_spr || (m_irr % DRIP_DIV) == 0) m_lvl = (m_lvl > 0) ? m_lvl - 1 : 0;
        if (m_lvl <= LOW_LVL) begin
          m_zone = -1;
          m_fill = 1;
        end
      end
    end else if (m_lvl <= LOW_LVL) begin
      m_fill = 1;
    end else begin
      for (int k = 1; k <= ZONES; k++) begin
        int z;
        z = (m_last + k) % ZONES;
        if (m_zone < 0 && (asp[z] ^ got[z])) begin
          m_zone = z; m_last = z; m_spr = asp[z]; m_fert = adb[z] && asp[z]; m_irr = 0;
        end
      end
    end
  endtask

  task automatic model_clock();
    if ((m_edges % PRESCALE) == PRESCALE - 1) model_tick();
    m_erro = asp & got;
    m_edges++;
  endtask

  task automatic compare_all();
    check_eq("tick",    32'(tick),       32'((m_edges % PRESCALE) == PRESCALE - 1));
    check_eq("level",   32'(cout_Nivel), 32'(m_lvl));
    check_eq("zone_on", 32'(zone_on),    (m_zone >= 0) ? 32'(1) << m_zone : 32'(0));
    check_eq("mode",    32'(mode),       32'(m_zone >= 0 && m_spr));
    check_eq("VE",      32'(VE),         32'(m_fill));
    check_eq("limpeza", 32'(limpeza),    (m_clean > 0) ? 32'(2) : (m_fert ? 32'(1) : 32'(0)));
    check_eq("erro",    32'(erro),       32'(m_erro));
  endtask

  // Called at a falling edge with inputs already applied for the next rising edge
  task automatic run_cycles(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd && $urandom_range(0, 7) == 0) begin
        asp = ZONES'($urandom);
        got = ZONES'($urandom);
        if ($urandom_range(0, 3) != 0) got = got & ~asp;
        adb = ZONES'($urandom);
      end
      model_clock();
      @(posedge clock);
      @(negedge clock);
      compare_all();
    end
  endtask

  task automatic check_zeroed(input string tag);
    check_eq({tag, "_zone_on"}, 32'(zone_on),    32'(0));
    check_eq({tag, "_mode"},    32'(mode),       32'(0));
    check_eq({tag, "_VE"},      32'(VE),         32'(0));
    check_eq({tag, "_level"},   32'(cout_Nivel), 32'(0));
    check_eq({tag, "_limpeza"}, 32'(limpeza),    32'(0));
    check_eq({tag, "_erro"},    32'(erro),       32'(0));
    check_eq({tag, "_tick"},    32'(tick),       32'(0));
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    #1 check_zeroed(tag);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clock);
    check_zeroed("por");
    @(negedge clock);
    reset = 1'b1;

    // Power-up fill from empty to full
    run_cycles(10 * PRESCALE, 0);
    check_eq("full_level", 32'(cout_Nivel), 32'(LEVEL_MAX));
    check_eq("fill_done",  32'(VE),         32'(0));

    // Sprinkler on zone 1 drains to the low threshold
    asp = 4'b0010;
    run_cycles(8 * PRESCALE, 0);
    asp = 4'b0000;
    run_cycles(8 * PRESCALE, 0);

    // Drip on zone 0
    got = 4'b0001;
    run_cycles(8 * PRESCALE, 0);
    got = 4'b0000;
    run_cycles(10 * PRESCALE, 0);

    // Conflicting request on zone 2
    asp = 4'b0100; got = 4'b0100;
    run_cycles(3 * PRESCALE, 0);
    asp = 4'b0000; got = 4'b0000;
    run_cycles(8 * PRESCALE, 0);

    // Round-robin between zones 0 and 3
    asp = 4'b1001;
    run_cycles(30 * PRESCALE, 0);
    asp = 4'b0000;
    run_cycles(12 * PRESCALE, 0);

    // Fertiliser run to completion
    asp = 4'b0010; adb = 4'b0010;
    run_cycles(2 * PRESCALE, 0);
    asp = 4'b0000;
    run_cycles(10 * PRESCALE, 0);
    adb = 4'b0000;
    run_cycles(10 * PRESCALE, 0);

    // Fertiliser run interrupted by reset during cleaning
    asp = 4'b0010; adb = 4'b0010;
    run_cycles(2 * PRESCALE, 0);
    check_eq("fert_pending", 32'(limpeza), 32'(1));
    asp = 4'b0000;
    run_cycles(3 * PRESCALE, 0);
    check_eq("cleaning", 32'(limpeza), 32'(2));
    do_reset("mid_clean");
    adb = 4'b0000;
    run_cycles(12 * PRESCALE, 0);

    // Random traffic with occasional resets
    for (int r = 0; r < 4; r++) begin
      run_cycles(600, 1);
      do_reset("rand_rst");
    end
    run_cycles(200, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
